rlwe_dmem_vec_bridge: RTL and testbench

// Sits directly downstream of the RLWE LSU: accepts its dmem request (byte/hword/word/vector) and drives a

---
 rtl/rlwe_dmem_vec_bridge_pkg.sv | 26 ++
 rtl/rlwe_dmem_vec_bridge.sv | 139 +++++++++++++
 tb/tb_rlwe_dmem_vec_bridge.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rlwe_dmem_vec_bridge_pkg.sv
// Shared memory-interface types for the RLWE dmem vector bridge.
package rlwe_dmem_vec_bridge_pkg;

    localparam int unsigned DEF_LANE   = 4;
    localparam int unsigned DEF_AWIDTH = 32;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE   = 2'b00,
        SCR1_MEM_WIDTH_HWORD  = 2'b01,
        SCR1_MEM_WIDTH_WORD   = 2'b10,
        SCR1_MEM_WIDTH_VECTOR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/rlwe_dmem_vec_bridge.sv
// Bridges an LSU dmem request (scalar or vector) onto a scalar 32-bit memory port.
// Vector accesses are issued as LANE word beats, one outstanding at a time; read
// beats are gathered into a lane buffer and a single response goes back to the LSU.
module rlwe_dmem_vec_bridge
    import rlwe_dmem_vec_bridge_pkg::*;
#(
    parameter int unsigned LANE   = DEF_LANE,
    parameter int unsigned AWIDTH = DEF_AWIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            lsu2dmem_req,
    input  type_scr1_mem_cmd_e              lsu2dmem_cmd,
    input  type_scr1_mem_width_e            lsu2dmem_width,
    input  logic [AWIDTH-1:0]               lsu2dmem_addr,
    input  logic [LANE-1:0][WORD_W-1:0]     lsu2dmem_wdata,
    output logic                            dmem2lsu_req_ack,
    output logic [LANE-1:0][WORD_W-1:0]     dmem2lsu_rdata,
    output type_scr1_mem_resp_e             dmem2lsu_resp,
    output logic                            mem_req,
    output type_scr1_mem_cmd_e              mem_cmd,
    output type_scr1_mem_width_e            mem_width,
    output logic [AWIDTH-1:0]               mem_addr,
    output logic [WORD_W-1:0]               mem_wdata,
    input  logic                            mem_req_ack,
    input  logic [WORD_W-1:0]               mem_rdata,
    input  type_scr1_mem_resp_e             mem_resp
);

    localparam int unsigned    CNT_W    = $clog2(LANE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RSP  = 2'b11
    } state_e;

    state_e                      r_state;
    state_e                      w_state_nxt;
    type_scr1_mem_cmd_e          r_cmd;
    type_scr1_mem_width_e        r_width;
    logic                        r_vec;
    logic [AWIDTH-1:0]           r_addr;
    logic [LANE-1:0][WORD_W-1:0] r_wdata;
    logic [LANE-1:0][WORD_W-1:0] r_rdata;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_last;

    assign w_accept = (r_state == ST_IDLE) && lsu2dmem_req;
    // A scalar access is a single beat, so its only beat is always the last one.
    assign w_last   = r_vec ? (r_cnt == CNT_LAST) : 1'b1;

    // Beat fields come straight from the latched request; only meaningful while mem_req is high.
    assign mem_cmd        = r_cmd;
    assign mem_width      = r_vec ? SCR1_MEM_WIDTH_WORD : r_width;
    assign mem_addr       = r_addr + AWIDTH'({r_cnt, 2'b00});
    assign mem_wdata      = r_wdata[r_cnt];
    assign dmem2lsu_rdata = r_rdata;

    // State register; reset abandons any transfer in flight without answering the LSU.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt      = r_state;
        dmem2lsu_req_ack = 1'b0;
        dmem2lsu_resp    = SCR1_MEM_RESP_NOTRDY;
        mem_req          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                dmem2lsu_req_ack = rst_n;
                if (lsu2dmem_req) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_req_ack) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                case (mem_resp)
                    SCR1_MEM_RESP_RDY_OK: w_state_nxt = w_last ? ST_RSP : ST_REQ;
                    SCR1_MEM_RESP_RDY_ER: w_state_nxt = ST_RSP;
                    default:              w_state_nxt = ST_WAIT;
                endcase
            end
            ST_RSP: begin
                dmem2lsu_resp = r_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, beat counter, error flag and lane capture buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd   <= SCR1_MEM_CMD_RD;
            r_width <= SCR1_MEM_WIDTH_BYTE;
            r_vec   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd   <= lsu2dmem_cmd;
                r_width <= lsu2dmem_width;
                r_vec   <= (lsu2dmem_width == SCR1_MEM_WIDTH_VECTOR);
                r_addr  <= lsu2dmem_addr;
                r_wdata <= lsu2dmem_wdata;
                r_rdata <= '0;
                r_cnt   <= '0;
                r_err   <= 1'b0;
            end
            if (r_state == ST_WAIT) begin
                if (mem_resp == SCR1_MEM_RESP_RDY_OK) begin
                    // Write beats never touch the buffer, so a store answers with zero data.
                    if (r_cmd == SCR1_MEM_CMD_RD) r_rdata[r_cnt] <= mem_rdata;
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end else if (mem_resp == SCR1_MEM_RESP_RDY_ER) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Memory must only answer while a beat is outstanding.
    a_resp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_resp != SCR1_MEM_RESP_NOTRDY) |-> (r_state == ST_WAIT));

endmodule

// File: tb/tb_rlwe_dmem_vec_bridge.sv
// Directed bench for rlwe_dmem_vec_bridge: a reactive memory, a request-level model
// of the beats and response each LSU request must produce, and a per-cycle compare.
module tb_rlwe_dmem_vec_bridge;
    import rlwe_dmem_vec_bridge_pkg::*;

    localparam int LANE = 4;
    localparam int AW   = 32;
    localparam int VW   = LANE * 32;

    typedef logic [LANE-1:0][31:0] vec_t;
    typedef struct {
        type_scr1_mem_cmd_e   cmd;
        type_scr1_mem_width_e width;
        logic [31:0]          addr;
        logic [31:0]          wdata;
    } beat_t;
    typedef struct {
        type_scr1_mem_resp_e resp;
        vec_t                rdata;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 lsu2dmem_req;
    type_scr1_mem_cmd_e   lsu2dmem_cmd;
    type_scr1_mem_width_e lsu2dmem_width;
    logic [AW-1:0]        lsu2dmem_addr;
    vec_t                 lsu2dmem_wdata;
    logic                 dmem2lsu_req_ack;
    vec_t                 dmem2lsu_rdata;
    type_scr1_mem_resp_e  dmem2lsu_resp;
    logic                 mem_req;
    type_scr1_mem_cmd_e   mem_cmd;
    type_scr1_mem_width_e mem_width;
    logic [AW-1:0]        mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_req_ack;
    logic [31:0]          mem_rdata;
    type_scr1_mem_resp_e  mem_resp;

    rlwe_dmem_vec_bridge #(.LANE(LANE), .AWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu2dmem_req(lsu2dmem_req), .lsu2dmem_cmd(lsu2dmem_cmd),
        .lsu2dmem_width(lsu2dmem_width), .lsu2dmem_addr(lsu2dmem_addr),
        .lsu2dmem_wdata(lsu2dmem_wdata), .dmem2lsu_req_ack(dmem2lsu_req_ack),
        .dmem2lsu_rdata(dmem2lsu_rdata), .dmem2lsu_resp(dmem2lsu_resp),
        .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req_ack(mem_req_ack),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory contents: 0xA0..0xA3 at 0x100..0x10C, otherwise a tag derived from the word address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
        return {16'hC0DE, a[15:2], 2'b00};
    endfunction

    // Memory knobs (set by the stimulus process).
    int ack_dly   = 0;
    int resp_dly  = 0;
    int err_beat  = -1;
    int hold_beat = -1;

    // Memory-side state and log of every accepted beat (written only by the memory process).
    beat_t lg[$];
    beat_t m_pb;
    int    m_pend = 0, m_adly = 0, m_rwait = 0, m_pidx = 0, m_beat = 0;

    // Reactive memory: decides ack/resp on the falling edge for the next rising edge.
    always @(negedge clk) begin
        mem_req_ack = 1'b0;
        mem_resp    = SCR1_MEM_RESP_NOTRDY;
        mem_rdata   = '0;
        if (rst_n !== 1'b1) begin
            m_pend = 0;
            m_adly = 0;
        end else begin
            if (lsu2dmem_req === 1'b1 && dmem2lsu_req_ack === 1'b1) m_beat = 0;
            if (m_pend != 0) begin
                if (m_rwait < resp_dly) m_rwait++;
                else if (m_pidx != hold_beat) begin
                    m_pend = 0;
                    if (m_pidx == err_beat) mem_resp = SCR1_MEM_RESP_RDY_ER;
                    else begin
                        mem_resp = SCR1_MEM_RESP_RDY_OK;
                        if (m_pb.cmd == SCR1_MEM_CMD_RD) mem_rdata = word_at(m_pb.addr);
                    end
                end
            end else if (mem_req === 1'b1) begin
                if (m_adly < ack_dly) m_adly++;
                else begin
                    m_adly      = 0;
                    mem_req_ack = 1'b1;
                    m_pend      = 1;
                    m_rwait     = 0;
                    m_pidx      = m_beat;
                    m_beat++;
                    m_pb = '{cmd: mem_cmd, width: mem_width, addr: mem_addr, wdata: mem_wdata};
                    lg.push_back(m_pb);
                end
            end
        end
    end

    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_resp = 0;
    beat_t exp_beats[$];
    rsp_t  exp_rsp[$];

    task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Compare process: every accepted beat and every LSU response against the model queues.
    task automatic monitor();
        beat_t b;
        rsp_t  r;
        forever begin
            @(negedge clk); #1;
            if (rst_n === 1'b1 && mem_req === 1'b1 && mem_req_ack === 1'b1) begin
                check("beat_expected", exp_beats.size() != 0, 1);
                if (exp_beats.size() != 0) begin
                    b = exp_beats.pop_front();
                    check("beat_addr", mem_addr, b.addr);
                    check("beat_cmd", mem_cmd, b.cmd);
                    check("beat_width", mem_width, b.width);
                    if (b.cmd == SCR1_MEM_CMD_WR) check("beat_wdata", mem_wdata, b.wdata);
                end
            end
            if (rst_n === 1'b1 && dmem2lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin
                n_resp++;
                check("rsp_expected", exp_rsp.size() != 0, 1);
                if (exp_rsp.size() != 0) begin
                    r = exp_rsp.pop_front();
                    check("rsp_code", dmem2lsu_resp, r.resp);
                    check("rsp_rdata", dmem2lsu_rdata, r.rdata);
                end
            end
        end
    endtask

    // Model one request (ek = failing beat, -1 for none) and hand it to the DUT.
    task automatic issue(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                         input logic [31:0] a, input vec_t wd, input int ek);
        int    n, last;
        beat_t b;
        rsp_t  r;
        n      = (w == SCR1_MEM_WIDTH_VECTOR) ? LANE : 1;
        last   = (ek >= 0 && ek < n) ? ek : n - 1;
        r.resp = (ek >= 0 && ek < n) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        r.rdata = '0;
        for (int k = 0; k <= last; k++) begin
            b.cmd   = cmd;
            b.width = (n > 1) ? SCR1_MEM_WIDTH_WORD : w;
            b.addr  = (n > 1) ? a + 32'(4 * k) : a;
            b.wdata = wd[k];
            exp_beats.push_back(b);
            if (cmd == SCR1_MEM_CMD_RD && k != ek) r.rdata[k] = word_at(b.addr);
        end
        exp_rsp.push_back(r);
        err_beat = ek;
        @(posedge clk); #1;
        lsu2dmem_req   = 1'b1;
        lsu2dmem_cmd   = cmd;
        lsu2dmem_width = w;
        lsu2dmem_addr  = a;
        lsu2dmem_wdata = wd;
        #1 check("req_ack", dmem2lsu_req_ack, 1);
        @(posedge clk); #1;
        lsu2dmem_req = 1'b0;
    endtask

    task automatic wait_resp(input int s, output int lat);
        lat = 0;
        while (n_resp == s && lat < 300) begin
            @(negedge clk); #2;
            lat++;
        end
        check("resp_seen", n_resp - s, 1);
        repeat (3) @(posedge clk);
        #1 check("resp_once", n_resp - s, 1);
        check("beats_drained", exp_beats.size(), 0);
    endtask

    task automatic do_req(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                          input logic [31:0] a, input vec_t wd, input int ek, output int lat);
        int s;
        s = n_resp;
        issue(cmd, w, a, wd, ek);
        wait_resp(s, lat);
    endtask

    initial begin
        vec_t wd;
        int   s, lat, cyc;
        rst_n          = 1'b0;
        lsu2dmem_req   = 1'b0;
        lsu2dmem_cmd   = SCR1_MEM_CMD_RD;
        lsu2dmem_width = SCR1_MEM_WIDTH_WORD;
        lsu2dmem_addr  = '0;
        lsu2dmem_wdata = '0;
        fork monitor(); join_none

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_ack_low", dmem2lsu_req_ack, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_resp", dmem2lsu_resp, SCR1_MEM_RESP_NOTRDY);
        check("rst_rdata", dmem2lsu_rdata, 0);
        rst_n = 1'b1;
        #1 check("idle_ack", dmem2lsu_req_ack, 1);

        // LV 0x100 zero-wait, with a request attempted while busy
        s = lg.size();
        cyc = n_resp;
        issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h100, '0, -1);
        lsu2dmem_req  = 1'b1;
        lsu2dmem_addr = 32'h500;
        #1 check("busy_no_ack", dmem2lsu_req_ack, 0);
        @(posedge clk); #1;
        lsu2dmem_req = 1'b0;
        wait_resp(cyc, lat);
        check("lv_nbeats", lg.size() - s, 4);
        for (int k = 0; k < 4; k++) check("lv_addr", lg[s + k].addr, 32'h100 + 32'(4 * k));
        check("lv_rdata", dmem2lsu_rdata, 128'h000000A3_000000A2_000000A1_000000A0);

        // SV 0x200 with ack delayed 2 cycles and one-cycle response delay
        ack_dly  = 2;
        resp_dly = 1;
        wd = '0;
        for (int k = 0; k < LANE; k++) wd[k] = 32'(k + 1);
        s = lg.size();
        do_req(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h200, wd, -1, lat);
        check("sv_nbeats", lg.size() - s, 4);
        for (int k = 0; k < 4; k++) begin
            check("sv_wdata", lg[s + k].wdata, 32'(k + 1));
            check("sv_cmd", lg[s + k].cmd, SCR1_MEM_CMD_WR);
            check("sv_width", lg[s + k].width, SCR1_MEM_WIDTH_WORD);
        end
        ack_dly  = 0;
        resp_dly = 0;

        // LW 0x44 and LB 0x45: single beats, raw word in lane 0
        s = lg.size();
        wd = '0;
        wd[0] = 32'h1234_5678;
        do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h44, wd, -1, lat);
        check("lw_width", lg[s].width, SCR1_MEM_WIDTH_WORD);
        check("lw_rdata", dmem2lsu_rdata, 128'h00000000_00000000_00000000_C0DE0044);
        s = lg.size();
        do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h45, '0, -1, lat);
        check("lb_nbeats", lg.size() - s, 1);
        check("lb_addr", lg[s].addr, 32'h45);
        check("lb_width", lg[s].width, SCR1_MEM_WIDTH_BYTE);

        // LV with error on beat 1: remaining beats skipped, next request accepted
        s = lg.size();
        do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h100, '0, 1, lat);
        check("er_nbeats", lg.size() - s, 2);
        check("er_rdata", dmem2lsu_rdata, 128'h00000000_00000000_00000000_000000A0);
        do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h44, '0, -1, lat);

        // LV across the top of the address space, zero-wait latency
        s = lg.size();
        do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'hFFFF_FFF8, '0, -1, lat);
        check("wrap_a0", lg[s].addr, 32'hFFFF_FFF8);
        check("wrap_a1", lg[s + 1].addr, 32'hFFFF_FFFC);
        check("wrap_a2", lg[s + 2].addr, 32'h0000_0000);
        check("wrap_a3", lg[s + 3].addr, 32'h0000_0004);
        check("vec_latency_min", lat >= 2 * LANE + 1, 1);

        // Reset while waiting on beat index 1: silent abort
        hold_beat = 1;
        s   = lg.size();
        cyc = n_resp;
        issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h100, '0, -1);
        lat = 0;
        while (lg.size() < s + 2 && lat < 100) begin
            @(negedge clk); #2;
            lat++;
        end
        check("rst_mid_beats", lg.size() - s, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_resp", dmem2lsu_resp, SCR1_MEM_RESP_NOTRDY);
        check("rst_mid_ack_low", dmem2lsu_req_ack, 0);
        exp_beats.delete();
        exp_rsp.delete();
        hold_beat = -1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 check("rst_mid_ack_after", dmem2lsu_req_ack, 1);
        repeat (4) @(posedge clk);
        #1 check("rst_mid_no_resp", n_resp - cyc, 0);
        do_req(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h108, '0, -1, lat);
        check("post_rst_rdata", dmem2lsu_rdata, 128'h00000000_00000000_00000000_000000A2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
